// File: rtl/dc_pred_multi.sv
// DC intra predictor for CHANNELS planes of BLOCK_SIZE^2 pixels, LANES edge samples per edge per cycle.
// Latency start->done BLOCK_SIZE/LANES+2 cycles (2 with no edges); start ignored while busy, no queueing.
module dc_pred_multi #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int LOG2_BLOCK = 3,
    parameter int CHANNELS   = 2,
    parameter int LANES      = 2,
    parameter int BLOCK_NUM  = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [BLOCK_NUM-1:0]                          x,
    input  logic [BLOCK_NUM-1:0]                          y,
    input  logic [BIT_WIDTH*BLOCK_SIZE*CHANNELS-1:0]      top,
    input  logic [BIT_WIDTH*BLOCK_SIZE*CHANNELS-1:0]      left,
    output logic                                          busy,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE*CHANNELS-1:0] dst,
    output logic                                          done
);

    localparam int ACC_W  = BIT_WIDTH + LOG2_BLOCK + 1;
    localparam int STEPS  = BLOCK_SIZE / LANES;
    localparam int CNT_W  = $clog2(STEPS) + 1;
    localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE * CHANNELS;
    localparam int PLANE_W = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [EDGE_W-1:0]  top_q;
    logic [EDGE_W-1:0]  left_q;
    logic               top_av;
    logic               left_av;
    logic [ACC_W-1:0]   acc      [CHANNELS];
    logic [ACC_W-1:0]   lane_sum [CHANNELS];
    logic [ACC_W-1:0]   tv;
    logic [ACC_W-1:0]   lv;

    // A missing edge is replaced by doubling the other, so the divisor stays 2*BLOCK_SIZE.
    always_comb begin
        tv = '0;
        lv = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            lane_sum[c] = '0;
            for (int l = 0; l < LANES; l++) begin
                tv = ACC_W'(top_q[BIT_WIDTH*(c*BLOCK_SIZE + int'(cnt)*LANES + l) +: BIT_WIDTH]);
                lv = ACC_W'(left_q[BIT_WIDTH*(c*BLOCK_SIZE + int'(cnt)*LANES + l) +: BIT_WIDTH]);
                if (top_av && left_av)
                    lane_sum[c] = lane_sum[c] + tv + lv;
                else if (top_av)
                    lane_sum[c] = lane_sum[c] + (tv << 1);
                else
                    lane_sum[c] = lane_sum[c] + (lv << 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dst     <= '0;
            cnt     <= '0;
            top_q   <= '0;
            left_q  <= '0;
            top_av  <= 1'b0;
            left_av <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                acc[c] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        top_q   <= top;
                        left_q  <= left;
                        top_av  <= |y;
                        left_av <= |x;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if ((|x) || (|y)) begin
                            state <= S_ACCUM;
                            for (int c = 0; c < CHANNELS; c++)
                                acc[c] <= '0;
                        end else begin
                            // Preload so the common rounding/shift in FINAL yields mid-grey.
                            state <= S_FINAL;
                            for (int c = 0; c < CHANNELS; c++)
                                acc[c] <= ACC_W'(128) << (LOG2_BLOCK + 1);
                        end
                    end
                end
                S_ACCUM: begin
                    for (int c = 0; c < CHANNELS; c++)
                        acc[c] <= acc[c] + lane_sum[c];
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        cnt   <= '0;
                        state <= S_FINAL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FINAL: begin
                    for (int c = 0; c < CHANNELS; c++)
                        dst[c*PLANE_W +: PLANE_W] <= {(BLOCK_SIZE*BLOCK_SIZE){
                            BIT_WIDTH'((acc[c] + ACC_W'(BLOCK_SIZE)) >> (LOG2_BLOCK + 1))}};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_pred_multi.sv
// Directed bench for dc_pred_multi at default parameters (N=8, LANES=2, 2 channels).
module tb_dc_pred_multi;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [127:0]  top;
    logic [127:0]  left;
    logic          busy;
    logic [1023:0] dst;
    logic          done;

    int n_chk = 0;
    int n_bad = 0;

    dc_pred_multi dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .top   (top),
        .left  (left),
        .busy  (busy),
        .dst   (dst),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_dst(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] g;
        logic [7:0] e;
        for (int c = 0; c < 2; c++) begin
            e = (c == 0) ? e0 : e1;
            g = e;
            for (int p = 0; p < 64; p++)
                if (dst[8*(c*64+p) +: 8] != e && g == e)
                    g = dst[8*(c*64+p) +: 8];
            check($sformatf("%s_ch%0d", tag, c), {24'd0, g}, {24'd0, e});
        end
    endtask

    task automatic set_uni(input logic [7:0] t0, input logic [7:0] l0,
                           input logic [7:0] t1, input logic [7:0] l1);
        top  = {{8{t1}}, {8{t0}}};
        left = {{8{l1}}, {8{l0}}};
    endtask

    // Pulses start and waits for done; lat counts edges from acceptance to the edge that shows done.
    task automatic go(input logic [9:0] xv, input logic [9:0] yv, output int lat, output int bcnt);
        x = xv;
        y = yv;
        start = 1'b1;
        lat = 0;
        bcnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        if (busy) bcnt++;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    int lat;
    int bcnt;
    int dcnt;
    int first_done;

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; y = '0; top = '0; left = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_dst", {31'd0, |dst}, 0);

        // Both edges, per-channel independence.
        set_uni(8'd10, 8'd20, 8'd255, 8'd0);
        go(10'd3, 10'd2, lat, bcnt);
        check("t1_lat", lat, 6);
        check("t1_busy_cycles", bcnt, 5);
        check_dst("t1", 8'd15, 8'd128);
        @(posedge clk); #1;
        check("t1_done_pulse", {31'd0, done}, 0);
        check_dst("t1_hold", 8'd15, 8'd128);

        // Top only: ramp on ch0, left driven all-ones must be ignored.
        top = '0;
        for (int i = 0; i < 8; i++) top[8*i +: 8] = 8'(i);
        for (int i = 0; i < 8; i++) top[8*(8+i) +: 8] = 8'd100;
        left = '1;
        go(10'd0, 10'd5, lat, bcnt);
        check("t2_lat", lat, 6);
        check_dst("t2", 8'd4, 8'd100);

        // No edges: fixed mid-grey, short path.
        set_uni(8'd77, 8'd33, 8'd1, 8'd2);
        go(10'd0, 10'd0, lat, bcnt);
        check("t3_lat", lat, 2);
        check("t3_busy_cycles", bcnt, 1);
        check_dst("t3", 8'd128, 8'd128);

        // Rounding: ch0 top all 1; ch1 a single left pixel of 7.
        set_uni(8'd1, 8'd0, 8'd0, 8'd0);
        left[8*(8+3) +: 8] = 8'd7;
        go(10'd1, 10'd1, lat, bcnt);
        check("t4_lat", lat, 6);
        check_dst("t4", 8'd1, 8'd0);

        // Saturated input must not wrap.
        set_uni(8'd255, 8'd255, 8'd255, 8'd255);
        go(10'd1, 10'd1, lat, bcnt);
        check_dst("t5", 8'd255, 8'd255);

        // Start while busy ignored; edges changed after acceptance have no effect.
        set_uni(8'd40, 8'd60, 8'd0, 8'd16);
        x = 10'd1; y = 10'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; top = '1; left = '1; x = '0; y = '0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; first_done = 0;
        for (int k = 3; k <= 20; k++) begin
            if (done) begin
                dcnt++;
                if (first_done == 0) first_done = k;
            end
            @(posedge clk); #1;
        end
        check("t6_done_count", dcnt, 1);
        check("t6_lat", first_done, 6);
        check_dst("t6", 8'd50, 8'd8);

        // Back-to-back: second start issued in the done cycle.
        set_uni(8'd10, 8'd10, 8'd10, 8'd10);
        go(10'd2, 10'd2, lat, bcnt);
        check_dst("t7a", 8'd10, 8'd10);
        set_uni(8'd30, 8'd50, 8'd200, 8'd100);
        go(10'd2, 10'd2, lat, bcnt);
        check("t7_lat", lat, 6);
        check_dst("t7b", 8'd40, 8'd150);

        // Reset mid-accumulation aborts without a done pulse.
        set_uni(8'd200, 8'd200, 8'd200, 8'd200);
        x = 10'd1; y = 10'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t8_busy", {31'd0, busy}, 0);
        check("t8_done", {31'd0, done}, 0);
        check("t8_dst", {31'd0, |dst}, 0);
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("t8_no_done", dcnt, 0);
        set_uni(8'd10, 8'd10, 8'd10, 8'd10);
        go(10'd1, 10'd1, lat, bcnt);
        check("t8_lat", lat, 6);
        check_dst("t8", 8'd10, 8'd10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
